// File: rtl/lpddr_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lpddr_wr_arb                                                  |
// | Purpose  : Shares the LPDDR controller AXI write port between the HT    |
// |            (graph) and MT (PPP) targets. AW is arbitrated by weighted   |
// |            round-robin, W is locked to the granted burst until WLAST,   |
// |            and B is demuxed on the MSB of the returned ID.              |
// | Ports    : i_clk/i_rst_n      clock, async active-low reset             |
// |            i_ht_weight        consecutive HT grants while MT waits      |
// |            i/o_{ht,mt}_aw_*   requester AW channels                     |
// |            i/o_{ht,mt}_w_*    requester W channels                      |
// |            i/o_{ht,mt}_b_*    requester B channels                      |
// |            o/i_aw_*,w_*,b_*   controller AXI write port (ID_W+1 IDs)    |
// |            o_err_wlast        sticky WLAST/AWLEN disagreement flag      |
// | Option   : LPDDR_WR_ARB_PERF_EN adds i_perf_clr and saturating per-     |
// |            source AW grant counters o_ht_grant_cnt / o_mt_grant_cnt.    |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module lpddr_wr_arb #(
  parameter int ID_W     = 8,
  parameter int ADDR_W   = 33,
  parameter int DATA_W   = 256,
  parameter int WEIGHT_W = 4,
  parameter int CNT_W    = 32,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [WEIGHT_W-1:0] i_ht_weight,
  // HT requester
  input  logic                i_ht_aw_valid,
  output logic                o_ht_aw_ready,
  input  logic [ID_W-1:0]     i_ht_aw_id,
  input  logic [ADDR_W-1:0]   i_ht_aw_addr,
  input  logic [7:0]          i_ht_aw_len,
  input  logic                i_ht_w_valid,
  input  logic                i_ht_w_last,
  output logic                o_ht_w_ready,
  input  logic [DATA_W-1:0]   i_ht_w_data,
  input  logic [STRB_W-1:0]   i_ht_w_strb,
  output logic                o_ht_b_valid,
  input  logic                i_ht_b_ready,
  output logic [ID_W-1:0]     o_ht_b_id,
  output logic [1:0]          o_ht_b_resp,
  // MT requester
  input  logic                i_mt_aw_valid,
  output logic                o_mt_aw_ready,
  input  logic [ID_W-1:0]     i_mt_aw_id,
  input  logic [ADDR_W-1:0]   i_mt_aw_addr,
  input  logic [7:0]          i_mt_aw_len,
  input  logic                i_mt_w_valid,
  input  logic                i_mt_w_last,
  output logic                o_mt_w_ready,
  input  logic [DATA_W-1:0]   i_mt_w_data,
  input  logic [STRB_W-1:0]   i_mt_w_strb,
  output logic                o_mt_b_valid,
  input  logic                i_mt_b_ready,
  output logic [ID_W-1:0]     o_mt_b_id,
  output logic [1:0]          o_mt_b_resp,
  // Controller port
  output logic                o_aw_valid,
  input  logic                i_aw_ready,
  output logic [ID_W:0]       o_aw_id,
  output logic [ADDR_W-1:0]   o_aw_addr,
  output logic [7:0]          o_aw_len,
  output logic                o_w_valid,
  output logic                o_w_last,
  input  logic                i_w_ready,
  output logic [DATA_W-1:0]   o_w_data,
  output logic [STRB_W-1:0]   o_w_strb,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [ID_W:0]       i_b_id,
  input  logic [1:0]          i_b_resp,
  output logic                o_err_wlast
`ifdef LPDDR_WR_ARB_PERF_EN
  ,
  input  logic                i_perf_clr,
  output logic [CNT_W-1:0]    o_ht_grant_cnt,
  output logic [CNT_W-1:0]    o_mt_grant_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AW_HT = 3'd1,
    S_AW_MT = 3'd2,
    S_W_HT  = 3'd3,
    S_W_MT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  // Consecutive HT grants since the last MT grant. Remaining credit is
  // weight_eff - ht_run_q; counting up keeps the reset value constant.
  logic [WEIGHT_W-1:0] ht_run_q, ht_run_d;
  logic [7:0]          len_q, len_d;
  logic [8:0]          beat_q, beat_d;
  logic                err_q, err_d;

  logic [WEIGHT_W-1:0] weight_eff;
  logic                has_credit;
  logic                w_hs;
  logic                w_last_sel;

  assign weight_eff = (i_ht_weight == '0) ? {{(WEIGHT_W-1){1'b0}}, 1'b1} : i_ht_weight;
  assign has_credit = (ht_run_q < weight_eff);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ht_run_q <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ht_run_q <= ht_run_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ht_run_d      = ht_run_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    o_aw_valid    = 1'b0;
    o_ht_aw_ready = 1'b0;
    o_mt_aw_ready = 1'b0;
    o_w_valid     = 1'b0;
    o_ht_w_ready  = 1'b0;
    o_mt_w_ready  = 1'b0;
    w_hs          = 1'b0;
    w_last_sel    = 1'b0;
    // Payloads follow the selected source; qualified by the valids above.
    if (state_q == S_AW_MT) begin
      o_aw_id   = {1'b1, i_mt_aw_id};
      o_aw_addr = i_mt_aw_addr;
      o_aw_len  = i_mt_aw_len;
    end else begin
      o_aw_id   = {1'b0, i_ht_aw_id};
      o_aw_addr = i_ht_aw_addr;
      o_aw_len  = i_ht_aw_len;
    end
    if (state_q == S_W_MT) begin
      o_w_data = i_mt_w_data;
      o_w_strb = i_mt_w_strb;
      o_w_last = i_mt_w_last;
    end else begin
      o_w_data = i_ht_w_data;
      o_w_strb = i_ht_w_strb;
      o_w_last = i_ht_w_last;
    end

    case (state_q)
      S_IDLE: begin
        if (i_ht_aw_valid && (!i_mt_aw_valid || has_credit)) begin
          state_d = S_AW_HT;
          // Credit saturates at zero when HT is granted alone.
          if (has_credit) ht_run_d = ht_run_q + 1'b1;
        end else if (i_mt_aw_valid) begin
          state_d  = S_AW_MT;
          ht_run_d = '0;
        end
      end
      S_AW_HT: begin
        o_aw_valid    = i_ht_aw_valid;
        o_ht_aw_ready = i_aw_ready;
        if (i_ht_aw_valid && i_aw_ready) begin
          len_d   = i_ht_aw_len;
          beat_d  = '0;
          state_d = S_W_HT;
        end
      end
      S_AW_MT: begin
        o_aw_valid    = i_mt_aw_valid;
        o_mt_aw_ready = i_aw_ready;
        if (i_mt_aw_valid && i_aw_ready) begin
          len_d   = i_mt_aw_len;
          beat_d  = '0;
          state_d = S_W_MT;
        end
      end
      S_W_HT: begin
        o_w_valid    = i_ht_w_valid;
        o_ht_w_ready = i_w_ready;
        w_hs         = i_ht_w_valid && i_w_ready;
        w_last_sel   = i_ht_w_last;
      end
      S_W_MT: begin
        o_w_valid    = i_mt_w_valid;
        o_mt_w_ready = i_w_ready;
        w_hs         = i_mt_w_valid && i_w_ready;
        w_last_sel   = i_mt_w_last;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_hs) begin
      // Flags both an early WLAST and a missing WLAST on the AWLEN beat.
      if (w_last_sel != (beat_q == {1'b0, len_q})) err_d = 1'b1;
      // Saturate so a runaway burst cannot wrap back onto len.
      if (beat_q != '1) beat_d = beat_q + 9'd1;
      if (w_last_sel) state_d = S_IDLE;
    end
  end

  assign o_err_wlast = err_q;

  // B return path is independent of the write FSM.
  assign o_ht_b_valid = i_b_valid & ~i_b_id[ID_W];
  assign o_mt_b_valid = i_b_valid &  i_b_id[ID_W];
  assign o_b_ready    = i_b_id[ID_W] ? i_mt_b_ready : i_ht_b_ready;
  assign o_ht_b_id    = i_b_id[ID_W-1:0];
  assign o_mt_b_id    = i_b_id[ID_W-1:0];
  assign o_ht_b_resp  = i_b_resp;
  assign o_mt_b_resp  = i_b_resp;

`ifdef LPDDR_WR_ARB_PERF_EN
  logic [CNT_W-1:0] ht_cnt_q, ht_cnt_d;
  logic [CNT_W-1:0] mt_cnt_q, mt_cnt_d;
  logic             ht_aw_hs, mt_aw_hs;

  assign ht_aw_hs = (state_q == S_AW_HT) && i_ht_aw_valid && i_aw_ready;
  assign mt_aw_hs = (state_q == S_AW_MT) && i_mt_aw_valid && i_aw_ready;

  always_comb begin
    ht_cnt_d = ht_cnt_q;
    mt_cnt_d = mt_cnt_q;
    if (i_perf_clr) begin
      ht_cnt_d = '0;
      mt_cnt_d = '0;
    end else begin
      if (ht_aw_hs && (ht_cnt_q != '1)) ht_cnt_d = ht_cnt_q + 1'b1;
      if (mt_aw_hs && (mt_cnt_q != '1)) mt_cnt_d = mt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ht_cnt_q <= '0;
      mt_cnt_q <= '0;
    end else begin
      ht_cnt_q <= ht_cnt_d;
      mt_cnt_q <= mt_cnt_d;
    end
  end

  assign o_ht_grant_cnt = ht_cnt_q;
  assign o_mt_grant_cnt = mt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpddr_wr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lpddr_wr_arb                                               |
// | Purpose  : Self-checking bench for lpddr_wr_arb: reset state, single     |
// |            burst, weighted arbitration order, AW stall, WLAST errors,    |
// |            B demux and mid-burst reset.                                  |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lpddr_wr_arb;
  localparam int ID_W     = 8;
  localparam int ADDR_W   = 33;
  localparam int DATA_W   = 256;
  localparam int WEIGHT_W = 4;
  localparam int CNT_W    = 32;
  localparam int STRB_W   = DATA_W / 8;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic [WEIGHT_W-1:0] i_ht_weight = '0;
  logic                i_ht_aw_valid = 0, i_mt_aw_valid = 0;
  logic                o_ht_aw_ready, o_mt_aw_ready;
  logic [ID_W-1:0]     i_ht_aw_id = '0, i_mt_aw_id = '0;
  logic [ADDR_W-1:0]   i_ht_aw_addr = '0, i_mt_aw_addr = '0;
  logic [7:0]          i_ht_aw_len = '0, i_mt_aw_len = '0;
  logic                i_ht_w_valid = 0, i_mt_w_valid = 0;
  logic                i_ht_w_last = 0, i_mt_w_last = 0;
  logic                o_ht_w_ready, o_mt_w_ready;
  logic [DATA_W-1:0]   i_ht_w_data = '0, i_mt_w_data = '0;
  logic [STRB_W-1:0]   i_ht_w_strb = '0, i_mt_w_strb = '0;
  logic                o_ht_b_valid, o_mt_b_valid;
  logic                i_ht_b_ready = 0, i_mt_b_ready = 0;
  logic [ID_W-1:0]     o_ht_b_id, o_mt_b_id;
  logic [1:0]          o_ht_b_resp, o_mt_b_resp;
  logic                o_aw_valid;
  logic                i_aw_ready = 0;
  logic [ID_W:0]       o_aw_id;
  logic [ADDR_W-1:0]   o_aw_addr;
  logic [7:0]          o_aw_len;
  logic                o_w_valid, o_w_last;
  logic                i_w_ready = 0;
  logic [DATA_W-1:0]   o_w_data;
  logic [STRB_W-1:0]   o_w_strb;
  logic                i_b_valid = 0;
  logic                o_b_ready;
  logic [ID_W:0]       i_b_id = '0;
  logic [1:0]          i_b_resp = '0;
  logic                o_err_wlast;
`ifdef LPDDR_WR_ARB_PERF_EN
  logic                i_perf_clr = 1'b0;
  logic [CNT_W-1:0]    o_ht_grant_cnt, o_mt_grant_cnt;
`endif

  lpddr_wr_arb #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ht_weight(i_ht_weight),
    .i_ht_aw_valid(i_ht_aw_valid), .o_ht_aw_ready(o_ht_aw_ready), .i_ht_aw_id(i_ht_aw_id),
    .i_ht_aw_addr(i_ht_aw_addr), .i_ht_aw_len(i_ht_aw_len),
    .i_ht_w_valid(i_ht_w_valid), .i_ht_w_last(i_ht_w_last), .o_ht_w_ready(o_ht_w_ready),
    .i_ht_w_data(i_ht_w_data), .i_ht_w_strb(i_ht_w_strb),
    .o_ht_b_valid(o_ht_b_valid), .i_ht_b_ready(i_ht_b_ready), .o_ht_b_id(o_ht_b_id),
    .o_ht_b_resp(o_ht_b_resp),
    .i_mt_aw_valid(i_mt_aw_valid), .o_mt_aw_ready(o_mt_aw_ready), .i_mt_aw_id(i_mt_aw_id),
    .i_mt_aw_addr(i_mt_aw_addr), .i_mt_aw_len(i_mt_aw_len),
    .i_mt_w_valid(i_mt_w_valid), .i_mt_w_last(i_mt_w_last), .o_mt_w_ready(o_mt_w_ready),
    .i_mt_w_data(i_mt_w_data), .i_mt_w_strb(i_mt_w_strb),
    .o_mt_b_valid(o_mt_b_valid), .i_mt_b_ready(i_mt_b_ready), .o_mt_b_id(o_mt_b_id),
    .o_mt_b_resp(o_mt_b_resp),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_id(o_aw_id),
    .o_aw_addr(o_aw_addr), .o_aw_len(o_aw_len),
    .o_w_valid(o_w_valid), .o_w_last(o_w_last), .i_w_ready(i_w_ready),
    .o_w_data(o_w_data), .o_w_strb(o_w_strb),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_id(i_b_id), .i_b_resp(i_b_resp),
    .o_err_wlast(o_err_wlast)
`ifdef LPDDR_WR_ARB_PERF_EN
    ,
    .i_perf_clr(i_perf_clr), .o_ht_grant_cnt(o_ht_grant_cnt), .o_mt_grant_cnt(o_mt_grant_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WEIGHT_W-1:0] weight;
    logic [7:0]          exp_mask;   // bit i set = i-th grant went to MT
  } arb_vec_t;

  typedef struct {
    logic          b_valid;
    logic [ID_W:0] b_id;
    logic [1:0]    b_resp;
    logic          ht_rdy;
    logic          mt_rdy;
    logic          exp_ht_v;
    logic          exp_mt_v;
    logic [ID_W-1:0] exp_id;
    logic          exp_b_rdy;
  } b_vec_t;

  arb_vec_t arb_tbl[4];
  b_vec_t   b_tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ht_aw_valid = 0; i_mt_aw_valid = 0;
    i_ht_w_valid  = 0; i_mt_w_valid  = 0;
    i_ht_w_last   = 0; i_mt_w_last   = 0;
    i_aw_ready    = 0; i_w_ready     = 0;
    i_b_valid     = 0; i_ht_b_ready  = 0; i_mt_b_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  // Drive one HT beat, check it is forwarded, then clock it in.
  task automatic ht_beat(input logic [7:0] idx, input logic last);
    i_ht_w_valid = 1'b1;
    i_ht_w_last  = last;
    i_ht_w_data  = DATA_W'(idx) + 256'h1000;
    i_ht_w_strb  = '1;
    #1;
    chk("w_valid_fwd", 64'(o_w_valid), 64'd1);
    chk("w_data_fwd",  64'(o_w_data[15:0]), 64'(16'h1000 + 16'(idx)));
    chk("w_last_fwd",  64'(o_w_last), 64'(last));
    chk("ht_w_ready",  64'(o_ht_w_ready), 64'd1);
    chk("mt_w_ready_blocked", 64'(o_mt_w_ready), 64'd0);
    step();
    i_ht_w_valid = 1'b0;
    i_ht_w_last  = 1'b0;
  endtask

  // IDLE -> AW_HT -> handshake; leaves the FSM in W_HT.
  task automatic ht_aw(input logic [7:0] len);
    i_ht_aw_valid = 1'b1;
    i_ht_aw_id    = 8'hAB;
    i_ht_aw_addr  = 33'h1_2345_6780;
    i_ht_aw_len   = len;
    i_aw_ready    = 1'b1;
    i_w_ready     = 1'b1;
    #1;
    chk("idle_no_aw", 64'(o_aw_valid), 64'd0);
    step();
    chk("aw_valid_ht", 64'(o_aw_valid), 64'd1);
    chk("aw_id_ht",    64'(o_aw_id), 64'h0AB);
    chk("aw_len_ht",   64'(o_aw_len), 64'(len));
    step();
    i_ht_aw_valid = 1'b0;
  endtask

  logic [7:0] seq;
  int         ngrant;

  initial begin
    arb_tbl[0] = '{weight: 4'd3, exp_mask: 8'h88};
    arb_tbl[1] = '{weight: 4'd0, exp_mask: 8'hAA};
    arb_tbl[2] = '{weight: 4'd1, exp_mask: 8'hAA};
    arb_tbl[3] = '{weight: 4'd2, exp_mask: 8'h24};

    b_tbl[0] = '{1'b1, 9'h122, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    b_tbl[1] = '{1'b1, 9'h0AB, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b1};
    b_tbl[2] = '{1'b1, 9'h0AB, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAB, 1'b0};
    b_tbl[3] = '{1'b0, 9'h133, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1};
    b_tbl[4] = '{1'b1, 9'h1FF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};

    i_ht_weight = 4'd3;
    do_reset();

    // Reset state
    chk("rst_aw_valid",    64'(o_aw_valid), 64'd0);
    chk("rst_w_valid",     64'(o_w_valid), 64'd0);
    chk("rst_ht_aw_ready", 64'(o_ht_aw_ready), 64'd0);
    chk("rst_mt_aw_ready", 64'(o_mt_aw_ready), 64'd0);
    chk("rst_ht_w_ready",  64'(o_ht_w_ready), 64'd0);
    chk("rst_mt_w_ready",  64'(o_mt_w_ready), 64'd0);
    chk("rst_b_ready",     64'(o_b_ready), 64'd0);
    chk("rst_err",         64'(o_err_wlast), 64'd0);

    // Single HT burst, len=3
    ht_aw(8'd3);
    for (int i = 0; i < 4; i++) ht_beat(8'(i), (i == 3));
    #1;
    chk("burst_back_idle", 64'(o_ht_w_ready), 64'd0);
    chk("burst_err",       64'(o_err_wlast), 64'd0);

    // Weighted round-robin order, len=0, both sides always requesting
    for (int r = 0; r < 4; r++) begin
      i_ht_weight = arb_tbl[r].weight;
      do_reset();
      i_ht_aw_id = 8'h11; i_mt_aw_id = 8'h22;
      i_ht_aw_len = 8'd0; i_mt_aw_len = 8'd0;
      i_ht_aw_valid = 1; i_mt_aw_valid = 1;
      i_ht_w_valid = 1;  i_mt_w_valid = 1;
      i_ht_w_last = 1;   i_mt_w_last = 1;
      i_aw_ready = 1;    i_w_ready = 1;
      seq = '0;
      ngrant = 0;
      for (int c = 0; c < 100 && ngrant < 8; c++) begin
        #1;
        if (o_aw_valid) begin
          seq[ngrant] = o_aw_id[ID_W];
          ngrant++;
        end
        step();
      end
      chk("arb_grant_count", 64'(ngrant), 64'd8);
      chk("arb_order", 64'(seq), 64'(arb_tbl[r].exp_mask));
      clear_inputs();
    end

    // AW stall on MT with controller not ready
    i_ht_weight = 4'd3;
    do_reset();
    i_mt_aw_valid = 1; i_mt_aw_id = 8'h5C; i_mt_aw_addr = 33'h0_DEAD_BEE0; i_mt_aw_len = 8'd0;
    i_ht_w_valid = 1;  i_w_ready = 1;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_aw_valid", 64'(o_aw_valid), 64'd1);
      chk("stall_aw_addr",  64'(o_aw_addr), 64'h0_DEAD_BEE0);
      chk("stall_aw_id",    64'(o_aw_id), 64'h15C);
      chk("stall_mt_ready", 64'(o_mt_aw_ready), 64'd0);
      chk("stall_ht_w_rdy", 64'(o_ht_w_ready), 64'd0);
      step();
    end
    i_aw_ready = 1;
    #1;
    chk("stall_release_ready", 64'(o_mt_aw_ready), 64'd1);
    step();
    i_mt_aw_valid = 0;
    i_mt_w_valid = 1; i_mt_w_last = 1; i_mt_w_data = 256'h77;
    #1;
    chk("mt_w_ready",     64'(o_mt_w_ready), 64'd1);
    chk("mt_w_data",      64'(o_w_data[7:0]), 64'h77);
    chk("mt_ht_w_rdy",    64'(o_ht_w_ready), 64'd0);
    step();
    i_mt_w_valid = 0; i_mt_w_last = 0; i_ht_w_valid = 0;
    #1;
    chk("mt_back_idle",   64'(o_mt_w_ready), 64'd0);
    chk("mt_err",         64'(o_err_wlast), 64'd0);

    // Early WLAST: len=1, last on first beat
    do_reset();
    ht_aw(8'd1);
    ht_beat(8'd0, 1'b1);
    chk("early_err",  64'(o_err_wlast), 64'd1);
    i_ht_w_valid = 1;
    #1;
    chk("early_idle", 64'(o_ht_w_ready), 64'd0);
    i_ht_w_valid = 0;

    // Late WLAST: len=1, last on third beat
    do_reset();
    chk("late_err_cleared", 64'(o_err_wlast), 64'd0);
    ht_aw(8'd1);
    ht_beat(8'd0, 1'b0);
    chk("late_err_beat0", 64'(o_err_wlast), 64'd0);
    ht_beat(8'd1, 1'b0);
    chk("late_err_beat1", 64'(o_err_wlast), 64'd1);
    ht_beat(8'd2, 1'b1);
    i_ht_w_valid = 1;
    #1;
    chk("late_idle", 64'(o_ht_w_ready), 64'd0);
    i_ht_w_valid = 0;

    // B channel demux
    for (int v = 0; v < 5; v++) begin
      i_b_valid = b_tbl[v].b_valid;
      i_b_id = b_tbl[v].b_id;
      i_b_resp = b_tbl[v].b_resp;
      i_ht_b_ready = b_tbl[v].ht_rdy;
      i_mt_b_ready = b_tbl[v].mt_rdy;
      #1;
      chk("b_ht_valid", 64'(o_ht_b_valid), 64'(b_tbl[v].exp_ht_v));
      chk("b_mt_valid", 64'(o_mt_b_valid), 64'(b_tbl[v].exp_mt_v));
      chk("b_ready",    64'(o_b_ready), 64'(b_tbl[v].exp_b_rdy));
      if (b_tbl[v].b_id[ID_W]) begin
        chk("b_mt_id",   64'(o_mt_b_id), 64'(b_tbl[v].exp_id));
        chk("b_mt_resp", 64'(o_mt_b_resp), 64'(b_tbl[v].b_resp));
      end else begin
        chk("b_ht_id",   64'(o_ht_b_id), 64'(b_tbl[v].exp_id));
        chk("b_ht_resp", 64'(o_ht_b_resp), 64'(b_tbl[v].b_resp));
      end
    end
    i_b_valid = 0; i_ht_b_ready = 0; i_mt_b_ready = 0;

    // Mid-burst reset with err flag already set from the late-WLAST run
    ht_aw(8'd3);
    ht_beat(8'd0, 1'b0);
    ht_beat(8'd1, 1'b0);
    i_ht_w_valid = 1;
    #1;
    chk("pre_rst_in_burst", 64'(o_ht_w_ready), 64'd1);
    i_rst_n = 0;
    #1;
    chk("rst_mid_w_valid", 64'(o_w_valid), 64'd0);
    chk("rst_mid_w_ready", 64'(o_ht_w_ready), 64'd0);
    chk("rst_mid_err",     64'(o_err_wlast), 64'd0);
    step();
    clear_inputs();
    step();
    i_rst_n = 1;
    i_ht_aw_valid = 1; i_mt_aw_valid = 1;
    i_ht_aw_id = 8'h01; i_mt_aw_id = 8'h02;
    step();
    chk("post_rst_aw_valid", 64'(o_aw_valid), 64'd1);
    chk("post_rst_grant_ht", 64'(o_aw_id), 64'h001);
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
